axilite_cmd_sequencer: RTL and testbench
========================================

AXILITE_CMD_SEQUENCER -- requirements
Module: axilite_cmd_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width, equal to the downstream AXI-Lite master's.
REQ-002 SHALL have parameter DATA_W, default 64: data width; DATA_W/8 strobe bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: command queue depth, a power of 2 and at least 2.
REQ-004 SHALL have parameter ERR_W, default 16: error counter width.
REQ-005 SHALL use one clock; reset is asynchronous and active-high. Ports below: name, direction, width, meaning.
REQ-006 aclk  in  1  clock.
REQ-007 areset  in  1  async active-high reset.
REQ-008 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-009 cmd_w_r, cmd_addr, cmd_data, cmd_strb  in  1, ADDR_W, DATA_W, DATA_W/8  command payload; cmd_w_r: 0=write, 1=read.
REQ-010 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-011 rsp_w_r, rsp_status, rsp_data  out  1, 2, DATA_W  response payload.
REQ-012 err_count  out  ERR_W  saturating count of non-OKAY responses.
REQ-013 fifo_level  out  $clog2(FIFO_DEPTH)+1  number of queued commands.
REQ-014 busy  out  1  high if queue non-empty, FSM not IDLE, or rsp_valid.
REQ-015 user_start, user_w_r, user_addr_in, user_data_in, user_data_strb  out  1, 1, ADDR_W, DATA_W, DATA_W/8  master request side.
REQ-016 user_free, user_status, user_data_out, user_data_out_en  in  1, 2, DATA_W, 1  master completion side.

Function
REQ-017 SHALL drive cmd_ready = (fifo_level < FIFO_DEPTH); push on cmd_valid&cmd_ready; no push/pop bypass when full.
REQ-018 SHALL run FSM states IDLE, ISSUE, WAIT, CAPTURE.
REQ-019 IDLE: if queue non-empty and rsp_valid==0, SHALL pop head into the command register and go to ISSUE.
REQ-020 A command pushed in cycle t SHALL reach ISSUE no earlier than cycle t+2.
REQ-021 ISSUE: user_start=1 with payload from the command register; SHALL go to WAIT in the first cycle user_free==0.
REQ-022 WAIT: user_start=0; on user_free==1 SHALL go to CAPTURE; if user_data_out_en==1 that cycle, SHALL latch user_data_out into rsp_data, else SHALL set rsp_data=0.
REQ-023 CAPTURE: SHALL latch user_status into rsp_status, set rsp_valid=1, copy rsp_w_r, increment err_count if status!=0, then return to IDLE.
REQ-024 user_addr_in, user_data_in, user_data_strb and user_w_r SHALL hold the command register value outside ISSUE, stable throughout ISSUE.
REQ-025 rsp_valid SHALL stay high with a stable payload until rsp_ready; it clears in the handshake cycle.
REQ-026 err_count SHALL saturate at 2^ERR_W-1.
REQ-027 Queue push SHALL continue while the FSM is busy or rsp_valid is stalled.

Reset
REQ-028 On areset SHALL immediately clear: FSM=IDLE, queue empty, fifo_level=0, cmd_ready=1, user_start=0, user_* payload=0, rsp_valid=0, rsp_*=0, err_count=0, busy=0.
REQ-029 Reset mid-operation SHALL discard queued and in-flight commands; the master is reset on the same event.

Structure
REQ-030 Package axilite_pkg SHALL hold the FSM state encodings and response codes OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11.
REQ-031 The queue SHALL be sub-module axilite_cmd_fifo: synchronous, power-of-2 depth, wrap-around pointers, extra-bit full/empty detection.

Verification
REQ-032 Write: addr 0x10, data 0xDEADBEEF, strb 0xFF, awready=1, bresp=00 -> one rsp with w_r=0, status=0, data=0; err_count=0.
REQ-033 Read: addr 0x20, slave returns 0x123456789ABCDEF0 with rresp=10 -> rsp_data=0x123456789ABCDEF0, status=2, err_count=1.
REQ-034 rsp_ready=0, push 6 commands back-to-back -> first completes and stalls; fifo_level=4, cmd_ready=0, sixth held off; no further user_start until rsp_ready=1.
REQ-035 awready held low 10 cycles -> user_start and addr stable for all 10 cycles; user_start low the cycle after user_free falls.
REQ-036 areset pulsed during WAIT with 3 queued -> all outputs at reset values immediately; fifo_level=0.
REQ-037 ERR_W=2, 5 SLVERR writes -> err_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/axilite_pkg.sv
// Shared definitions for the AXI-Lite command sequencer.
// Covers the FSM state encoding and the AXI response codes.
package axilite_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } seq_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Anything other than OKAY is counted as an error, including EXOKAY.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axilite_cmd_fifo.sv
// Command queue: power-of-2 depth, wrap-around pointers with an extra
// MSB that tells full from empty. The head entry is readable without a pop.
module axilite_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // A push is refused when full even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
    end

    assign head_data = mem[rd_ptr_reg[PTR_W-1:0]];
    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign full      = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                       (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign level     = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: rtl/axilite_cmd_sequencer.sv
// Queues AXI-Lite commands and hands them one at a time to a user-side
// AXI-Lite master, returning one response per command and counting errors.
module axilite_cmd_sequencer
    import axilite_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int ERR_W      = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_w_r,
    input  logic [ADDR_W-1:0]           cmd_addr,
    input  logic [DATA_W-1:0]           cmd_data,
    input  logic [DATA_W/8-1:0]         cmd_strb,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_w_r,
    output logic [1:0]                  rsp_status,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [ERR_W-1:0]            err_count,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy,
    output logic                        user_start,
    output logic                        user_w_r,
    output logic [ADDR_W-1:0]           user_addr_in,
    output logic [DATA_W-1:0]           user_data_in,
    output logic [DATA_W/8-1:0]         user_data_strb,
    input  logic                        user_free,
    input  logic [1:0]                  user_status,
    input  logic [DATA_W-1:0]           user_data_out,
    input  logic                        user_data_out_en
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CMD_W  = 1 + ADDR_W + DATA_W + STRB_W;

    seq_state_t       state_reg;
    seq_state_t       state_next;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [CMD_W-1:0] head_data;

    axilite_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .aclk      (aclk),
        .areset    (areset),
        .push      (cmd_valid && cmd_ready),
        .push_data ({cmd_w_r, cmd_addr, cmd_data, cmd_strb}),
        .pop       (fifo_pop),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign cmd_ready = !fifo_full;
    assign busy      = !fifo_empty || (state_reg != ST_IDLE) || rsp_valid;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        fifo_pop   = 1'b0;
        user_start = 1'b0;
        case (state_reg)
            // A stalled response blocks the next issue so responses never overlap.
            ST_IDLE: begin
                if (!fifo_empty && !rsp_valid) begin
                    fifo_pop   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                user_start = 1'b1;
                if (!user_free) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (user_free) state_next = ST_CAPTURE;
            end
            ST_CAPTURE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            user_w_r       <= 1'b0;
            user_addr_in   <= '0;
            user_data_in   <= '0;
            user_data_strb <= '0;
            rsp_valid      <= 1'b0;
            rsp_w_r        <= 1'b0;
            rsp_status     <= RESP_OKAY;
            rsp_data       <= '0;
            err_count      <= '0;
        end else begin
            if (fifo_pop) begin
                {user_w_r, user_addr_in, user_data_in, user_data_strb} <= head_data;
            end
            if (state_reg == ST_WAIT && user_free) begin
                rsp_data <= user_data_out_en ? user_data_out : '0;
            end
            if (state_reg == ST_CAPTURE) begin
                rsp_status <= user_status;
                rsp_valid  <= 1'b1;
                rsp_w_r    <= user_w_r;
                if (resp_is_error(user_status) && (err_count != '1)) begin
                    err_count <= err_count + 1'b1;
                end
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axilite_cmd_sequencer.sv
// Randomized self-checking bench: a behavioural AXI-Lite master answers each
// issued command from a plan queue, and a scoreboard checks every response.
module tb_axilite_cmd_sequencer;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int EW = 2;

    typedef struct {
        logic          w_r;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [7:0]    strb;
        logic [1:0]    st;
        logic [DW-1:0] rd;
    } cmd_t;

    typedef struct {
        logic          w_r;
        logic [1:0]    st;
        logic [DW-1:0] data;
    } rsp_t;

    logic          aclk;
    logic          areset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_w_r;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic [7:0]    cmd_strb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_w_r;
    logic [1:0]    rsp_status;
    logic [DW-1:0] rsp_data;
    logic [EW-1:0] err_count;
    logic [2:0]    fifo_level;
    logic          busy;
    logic          user_start;
    logic          user_w_r;
    logic [AW-1:0] user_addr_in;
    logic [DW-1:0] user_data_in;
    logic [7:0]    user_data_strb;
    logic          user_free;
    logic [1:0]    user_status;
    logic [DW-1:0] user_data_out;
    logic          user_data_out_en;

    axilite_cmd_sequencer #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (4),
        .ERR_W      (EW)
    ) dut (
        .aclk             (aclk),
        .areset           (areset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_w_r          (cmd_w_r),
        .cmd_addr         (cmd_addr),
        .cmd_data         (cmd_data),
        .cmd_strb         (cmd_strb),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_w_r          (rsp_w_r),
        .rsp_status       (rsp_status),
        .rsp_data         (rsp_data),
        .err_count        (err_count),
        .fifo_level       (fifo_level),
        .busy             (busy),
        .user_start       (user_start),
        .user_w_r         (user_w_r),
        .user_addr_in     (user_addr_in),
        .user_data_in     (user_data_in),
        .user_data_strb   (user_data_strb),
        .user_free        (user_free),
        .user_status      (user_status),
        .user_data_out    (user_data_out),
        .user_data_out_en (user_data_out_en)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int   n_checks = 0;
    int   n_errors = 0;
    cmd_t plan_q[$];
    rsp_t exp_q[$];
    int   err_model = 0;
    int   rsp_seen = 0;
    int   start_count = 0;
    int   m_state = 0;
    bit   rand_delays = 0;
    int   fix_acc = 0;
    int   fix_rsp = 0;
    bit   rdy_rand = 0;
    logic rdy_level = 1'b1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural user-side master: accepts after acc_dly cycles, answers after rsp_dly.
    initial begin : master
        cmd_t cur;
        int   m_cnt;
        int   acc_dly;
        int   rsp_dly;
        rsp_t r;
        user_free = 1'b1; user_status = 2'b00; user_data_out = '0; user_data_out_en = 1'b0;
        m_cnt = 0; acc_dly = 0; rsp_dly = 0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                m_state = 0; user_free = 1'b1; user_status = 2'b00;
                user_data_out = '0; user_data_out_en = 1'b0;
            end else begin
                if (m_state == 0 && user_start) begin
                    start_count++;
                    check_val("start_rsp_idle", rsp_valid, 0);
                    check_val("start_planned", plan_q.size() > 0, 1);
                    if (plan_q.size() > 0) cur = plan_q.pop_front();
                    check_val("start_w_r", user_w_r, cur.w_r);
                    check_val("start_addr", user_addr_in, cur.addr);
                    check_val("start_data", user_data_in, cur.data);
                    check_val("start_strb", user_data_strb, cur.strb);
                    acc_dly = rand_delays ? $urandom_range(0, 3) : fix_acc;
                    rsp_dly = rand_delays ? $urandom_range(0, 3) : fix_rsp;
                    m_cnt = 0;
                    m_state = 1;
                end else if (m_state == 1) begin
                    check_val("start_hold", user_start, 1);
                    check_val("addr_hold", user_addr_in, cur.addr);
                    m_cnt++;
                end else if (m_state == 2) begin
                    if (m_cnt == 0) check_val("start_drop", user_start, 0);
                    if (m_cnt >= rsp_dly) begin
                        user_free = 1'b1;
                        user_status = cur.st;
                        user_data_out_en = cur.w_r;
                        user_data_out = cur.w_r ? cur.rd : {$urandom, $urandom};
                        r.w_r = cur.w_r;
                        r.st = cur.st;
                        r.data = cur.w_r ? cur.rd : '0;
                        exp_q.push_back(r);
                        m_state = 0;
                    end else begin
                        m_cnt++;
                    end
                end
                if (m_state == 1 && m_cnt >= acc_dly) begin
                    user_free = 1'b0;
                    m_cnt = 0;
                    m_state = 2;
                end
            end
        end
    end

    initial begin : ready_driver
        rsp_ready = 1'b0;
        forever begin
            @(negedge aclk);
            rsp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_level;
        end
    end

    // Scoreboard: payload must match the head expectation every cycle it is valid.
    initial begin : rsp_monitor
        rsp_t e;
        forever begin
            @(negedge aclk);
            #1;
            if (!areset && rsp_valid) begin
                check_val("rsp_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    check_val("rsp_w_r", rsp_w_r, e.w_r);
                    check_val("rsp_status", rsp_status, e.st);
                    check_val("rsp_data", rsp_data, e.data);
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        if (e.st != 2'b00 && err_model < (1 << EW) - 1) err_model++;
                        check_val("err_count", err_count, err_model);
                        rsp_seen++;
                        $display("rsp %0d: w_r=%0d status=%0d data=%h err_count=%0d",
                                 rsp_seen, rsp_w_r, rsp_status, rsp_data, err_count);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [7:0] s, input logic [1:0] st, input logic [DW-1:0] rd);
        int   n;
        cmd_t c;
        n = 0;
        cmd_valid = 1'b1; cmd_w_r = w; cmd_addr = a; cmd_data = d; cmd_strb = s;
        while (!cmd_ready && n < 500) begin
            @(negedge aclk);
            n++;
        end
        check_val("cmd_accept", cmd_ready, 1);
        if (cmd_ready) begin
            c.w_r = w; c.addr = a; c.data = d; c.strb = s; c.st = st; c.rd = rd;
            plan_q.push_back(c);
        end
        @(negedge aclk);
    endtask

    task automatic cmd_idle();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || plan_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        check_val("idle_busy", busy, 0);
        check_val("idle_drained", plan_q.size() + exp_q.size(), 0);
    endtask

    task automatic check_reset_state();
        check_val("rst_fifo_level", fifo_level, 0);
        check_val("rst_cmd_ready", cmd_ready, 1);
        check_val("rst_user_start", user_start, 0);
        check_val("rst_user_w_r", user_w_r, 0);
        check_val("rst_user_addr", user_addr_in, 0);
        check_val("rst_user_data", user_data_in, 0);
        check_val("rst_user_strb", user_data_strb, 0);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_rsp_w_r", rsp_w_r, 0);
        check_val("rst_rsp_status", rsp_status, 0);
        check_val("rst_rsp_data", rsp_data, 0);
        check_val("rst_err_count", err_count, 0);
        check_val("rst_busy", busy, 0);
    endtask

    initial begin : stimulus
        int   n;
        int   sc0;
        int   sat_exp[5];
        cmd_t c;
        areset = 1'b1;
        cmd_valid = 1'b0; cmd_w_r = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_strb = '0;
        sat_exp = '{1, 2, 3, 3, 3};
        repeat (2) @(negedge aclk);
        check_reset_state();
        areset = 1'b0;
        @(negedge aclk);

        // Single write, OKAY.
        send_cmd(1'b0, 32'h10, 64'hDEADBEEF, 8'hFF, 2'b00, '0);
        cmd_idle();
        wait_idle();
        check_val("write_err", err_count, 0);
        check_val("write_rsp_count", rsp_seen, 1);

        // Single read returning SLVERR with data.
        send_cmd(1'b1, 32'h20, {$urandom, $urandom}, 8'h00, 2'b10, 64'h123456789ABCDEF0);
        cmd_idle();
        wait_idle();
        check_val("read_err", err_count, 1);
        check_val("read_rsp_count", rsp_seen, 2);

        // Slow acceptance: start and payload must hold for every waiting cycle.
        fix_acc = 10;
        send_cmd(1'b0, 32'h44, 64'h0123_4567_89AB_CDEF, 8'h0F, 2'b00, '0);
        cmd_idle();
        wait_idle();
        fix_acc = 0;

        // Stalled response with a burst of six commands.
        rdy_level = 1'b0;
        sc0 = start_count;
        for (int i = 0; i < 5; i++) begin
            send_cmd(1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom}, 8'($urandom), 2'b00, {$urandom, $urandom});
        end
        c.w_r = 1'b1; c.addr = $urandom; c.data = {$urandom, $urandom}; c.strb = 8'hA5;
        c.st = 2'b01; c.rd = {$urandom, $urandom};
        cmd_valid = 1'b1; cmd_w_r = c.w_r; cmd_addr = c.addr; cmd_data = c.data; cmd_strb = c.strb;
        repeat (20) @(negedge aclk);
        check_val("stall_level", fifo_level, 4);
        check_val("stall_cmd_ready", cmd_ready, 0);
        check_val("stall_starts", start_count, sc0 + 1);
        check_val("stall_rsp_valid", rsp_valid, 1);
        rdy_level = 1'b1;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check_val("sixth_accept", cmd_ready, 1);
        if (cmd_ready) plan_q.push_back(c);
        @(negedge aclk);
        cmd_idle();
        wait_idle();
        check_val("stall_total_starts", start_count, sc0 + 6);

        // Random traffic with random master latency and random rsp_ready.
        rand_delays = 1;
        rdy_rand = 1;
        for (int i = 0; i < 40; i++) begin
            send_cmd(1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom}, 8'($urandom),
                     2'($urandom_range(0, 3)), {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) begin
                cmd_idle();
                repeat ($urandom_range(1, 3)) @(negedge aclk);
            end
        end
        cmd_idle();
        rdy_rand = 0;
        rdy_level = 1'b1;
        wait_idle();
        rand_delays = 0;

        // Reset while a command is in WAIT with three more queued.
        fix_rsp = 30;
        for (int i = 0; i < 4; i++) begin
            send_cmd(1'b0, $urandom, {$urandom, $urandom}, 8'hFF, 2'b10, '0);
        end
        cmd_idle();
        n = 0;
        while (m_state != 2 && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check_val("pre_rst_level", fifo_level, 3);
        check_val("pre_rst_busy", busy, 1);
        #2 areset = 1'b1;
        #1 check_reset_state();
        plan_q.delete();
        exp_q.delete();
        err_model = 0;
        fix_rsp = 0;
        sc0 = start_count;
        @(negedge aclk);
        @(negedge aclk);
        #2 areset = 1'b0;
        repeat (5) @(negedge aclk);
        check_val("post_rst_level", fifo_level, 0);
        check_val("post_rst_busy", busy, 0);
        check_val("post_rst_starts", start_count, sc0);

        // Error counter saturation with a 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            send_cmd(1'b0, $urandom, {$urandom, $urandom}, 8'hFF, 2'b10, '0);
            cmd_idle();
            wait_idle();
            check_val("err_sat", err_count, 64'(sat_exp[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
